// File: rtl/vsched_pkg.sv
// vsched_pkg: shared constants for the vertical-blanking update scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vsched_pkg;

  // Upper bound on the number of requesters a single scheduler can serve.
  localparam int N_REQ_MAX = 8;

  // FSM encodings, kept as plain constants so legacy code can compare against them.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SELECT   = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_GAP      = 2'd3;

  // Timer must be able to hold the value TIMEOUT itself.
  function automatic int timer_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Index must be able to hold N_REQ ("past the last requester").
  function automatic int idx_w(input int n_req);
    return $clog2(n_req + 1);
  endfunction

endpackage

// File: rtl/vblank_update_scheduler_sync_edge_detect.sv
// sync_edge_detect: single-flop edge detector on the pixel clock.
// Latency: pulse is combinational from d against last cycle's sample (1 cycle wide).
// Backpressure: none; free-running.
// Ports: clk_vga, rst (sync, active-high), d (level in), pulse (edge out).
// RESET_VAL seeds the history flop so no edge is reported right after reset;
// RISE selects rising (1) or falling (0) edge detection.
module sync_edge_detect #(
  parameter logic RESET_VAL = 1'b1,
  parameter bit   RISE      = 1'b0
) (
  input  logic clk_vga,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic q;

  always_ff @(posedge clk_vga) begin
    if (rst) q <= RESET_VAL;
    else     q <= d;
  end

  assign pulse = RISE ? (d & ~q) : (~d & q);

endmodule

// File: rtl/vblank_update_scheduler.sv
// vblank_update_scheduler: hands out one update slot per enabled requester per frame during vblank.
// Latency: VS fall sampled at edge t -> first upd_req high after edge t+2; >=1 idle cycle between grants.
// Backpressure: each grant is held until upd_ack or TIMEOUT cycles; active video or a new frame aborts the sequence.
// Ports: clk_vga, rst (sync, active-high), VGA_VS, VGA_BLANK_N, enable_mask, upd_ack, err_clr (in);
//        upd_req, busy, frame_cnt, timeout_err, overrun (out);
//        sched_cycles, sched_max (out, only when VSCHED_PERF_EN is defined).
module vblank_update_scheduler
  import vsched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk_vga,
  input  logic             rst,
  input  logic             VGA_VS,
  input  logic             VGA_BLANK_N,
  input  logic [N_REQ-1:0] enable_mask,
  input  logic [N_REQ-1:0] upd_ack,
  input  logic             err_clr,
  output logic [N_REQ-1:0] upd_req,
  output logic             busy,
  output logic [15:0]      frame_cnt,
  output logic [N_REQ-1:0] timeout_err,
  output logic             overrun
`ifdef VSCHED_PERF_EN
  ,
  output logic [15:0]      sched_cycles,
  output logic [15:0]      sched_max
`endif
);

  localparam int TIMER_W = timer_w(TIMEOUT);
  localparam int IDX_W   = idx_w(N_REQ);

  logic               trigger;
  logic               deadline;
  logic [1:0]         state;
  logic [N_REQ-1:0]   mask_q;
  logic [IDX_W-1:0]   idx;
  logic [TIMER_W-1:0] timer;
  logic               sel_vld;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found_c;
  logic [IDX_W-1:0]   sel_idx_c;
  logic [N_REQ-1:0]   grant_vec;
  logic               ack_hit;
  logic               timeout_hit;
  logic               done_now;
  logic [IDX_W-1:0]   idx_eff;
  logic               pending;
  logic               overrun_set;
  logic [N_REQ-1:0]   timeout_set;

  sync_edge_detect #(.RESET_VAL(1'b1), .RISE(1'b0)) u_vs_fall (
    .clk_vga (clk_vga),
    .rst     (rst),
    .d       (VGA_VS),
    .pulse   (trigger)
  );

  sync_edge_detect #(.RESET_VAL(1'b1), .RISE(1'b1)) u_blank_rise (
    .clk_vga (clk_vga),
    .rst     (rst),
    .d       (VGA_BLANK_N),
    .pulse   (deadline)
  );

  // Lowest enabled requester at or above idx. Descending loop so the lowest hit wins.
  always_comb begin
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (mask_q[j] && (IDX_W'(j) >= idx)) begin
        sel_found_c = 1'b1;
        sel_idx_c   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    for (int j = 0; j < N_REQ; j++) begin
      grant_vec[j] = (IDX_W'(j) == sel_idx);
    end
  end

  // upd_req is one-hot on the granted requester, so masking the acks with it
  // ignores acks on every other bit.
  assign ack_hit     = (state == ST_WAIT_ACK) && (|(upd_ack & upd_req));
  assign timeout_hit = (state == ST_WAIT_ACK) && !ack_hit &&
                       (timer == TIMER_W'(TIMEOUT - 1));
  assign done_now    = ack_hit | timeout_hit;

  // A requester finishing in the same cycle as the deadline counts as served.
  assign idx_eff = idx + IDX_W'(done_now);

  always_comb begin
    pending = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (mask_q[j] && (IDX_W'(j) >= idx_eff)) pending = 1'b1;
    end
  end

  assign overrun_set = busy && (trigger || (deadline && pending));
  assign timeout_set = (timeout_hit && !trigger) ? upd_req : '0;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state       <= ST_IDLE;
      mask_q      <= '0;
      idx         <= '0;
      timer       <= '0;
      sel_vld     <= 1'b0;
      sel_found   <= 1'b0;
      sel_idx     <= '0;
      upd_req     <= '0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
      timeout_err <= '0;
      overrun     <= 1'b0;
    end else begin
      // The priority search is registered; its result is only trusted one
      // cycle after mask/idx are reloaded by a trigger.
      sel_found <= sel_found_c;
      sel_idx   <= sel_idx_c;
      sel_vld   <= 1'b1;

      // New errors take precedence over a simultaneous clear.
      timeout_err <= (err_clr ? '0 : timeout_err) | timeout_set;
      overrun     <= (err_clr ? 1'b0 : overrun) | overrun_set;

      if (trigger) begin
        mask_q    <= enable_mask;
        idx       <= '0;
        timer     <= '0;
        frame_cnt <= frame_cnt + 16'd1;
        busy      <= 1'b1;
        upd_req   <= '0;
        sel_vld   <= 1'b0;
        state     <= ST_SELECT;
      end else if (busy && deadline) begin
        upd_req <= '0;
        busy    <= 1'b0;
        state   <= ST_IDLE;
      end else begin
        case (state)
          ST_SELECT: begin
            if (sel_vld) begin
              if (sel_found) begin
                upd_req <= grant_vec;
                idx     <= sel_idx;
                timer   <= '0;
                state   <= ST_WAIT_ACK;
              end else begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
          ST_WAIT_ACK: begin
            if (done_now) begin
              upd_req <= '0;
              idx     <= idx + IDX_W'(1);
              state   <= ST_GAP;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          ST_GAP: begin
            state <= ST_SELECT;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef VSCHED_PERF_EN
  logic [15:0] run_cnt;
  logic        seq_end;

  // A sequence ends on normal completion, on a deadline abort, or when a new
  // trigger restarts it.
  assign seq_end = busy && (trigger || deadline ||
                   ((state == ST_SELECT) && sel_vld && !sel_found));

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      run_cnt      <= '0;
      sched_cycles <= '0;
      sched_max    <= '0;
    end else begin
      if (seq_end) begin
        sched_cycles <= run_cnt;
        if (run_cnt > sched_max) sched_max <= run_cnt;
      end
      // run_cnt holds the number of edges since the trigger, saturating.
      if (trigger) begin
        run_cnt <= 16'd1;
      end else if (busy && (run_cnt != 16'hFFFF)) begin
        run_cnt <= run_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vblank_update_scheduler.sv
module tb_vblank_update_scheduler;

  localparam int NR    = 4;
  localparam int NEVER = 1000;

  logic          clk_vga = 1'b0;
  logic          rst;
  logic          VGA_VS;
  logic          VGA_BLANK_N;
  logic          err_clr;
  logic [NR-1:0] enable_mask;
  logic [NR-1:0] upd_ack;
  logic [NR-1:0] upd_req;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic [NR-1:0] timeout_err;
  logic          overrun;

  int checks   = 0;
  int failures = 0;

  vblank_update_scheduler #(.N_REQ(NR), .TIMEOUT(16)) dut (
    .clk_vga     (clk_vga),
    .rst         (rst),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .enable_mask (enable_mask),
    .upd_ack     (upd_ack),
    .err_clr     (err_clr),
    .upd_req     (upd_req),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clk_vga = ~clk_vga;

  // Per-frame stimulus knobs and observations.
  int            ack_dly [NR];
  int            ack_cnt [NR];
  int            dl_at, clr_at, retrig_at;
  logic [NR-1:0] mask2;
  int            n_grants, first_req, busy_drop, gap_min, gap_max, low_run;
  int            grant_len [8];
  logic [31:0]   order;
  logic [NR-1:0] req_or;

  task automatic step();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Index of a one-hot grant; 14 marks a non-one-hot vector (logged as 0xF).
  function automatic int oh2idx(input logic [NR-1:0] v);
    int r;
    int n;
    r = 14;
    n = 0;
    for (int i = 0; i < NR; i++) begin
      if (v[i]) begin
        r = i;
        n++;
      end
    end
    return (n == 1) ? r : 14;
  endfunction

  // Cycle c is sampled 1 time unit after the c-th edge following the trigger edge.
  task automatic run_frame(input logic [NR-1:0] mask, input int budget);
    logic [NR-1:0] prev_req;
    n_grants  = 0;
    first_req = -1;
    busy_drop = -1;
    gap_min   = 999;
    gap_max   = -1;
    low_run   = 0;
    order     = '0;
    req_or    = '0;
    prev_req  = '0;
    for (int i = 0; i < 8; i++) grant_len[i] = 0;
    for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
    upd_ack     = '0;
    enable_mask = mask;
    VGA_BLANK_N = 1'b0;
    step();
    VGA_VS = 1'b0;
    step();
    VGA_VS = 1'b1;
    chk("trig_busy", {31'd0, busy}, 32'd1);
    chk("trig_req_low", {28'd0, upd_req}, 32'd0);
    for (int c = 1; c <= budget; c++) begin
      if (c == dl_at) VGA_BLANK_N = 1'b1;
      err_clr = (c == clr_at);
      if (c == retrig_at) begin
        VGA_VS      = 1'b0;
        enable_mask = mask2;
      end else begin
        VGA_VS = 1'b1;
      end
      step();
      if (upd_req != '0) begin
        if (prev_req == '0) begin
          if (n_grants == 0) begin
            first_req = c;
          end else begin
            if (low_run < gap_min) gap_min = low_run;
            if (low_run > gap_max) gap_max = low_run;
          end
          order = (order << 4) | 32'(oh2idx(upd_req) + 1);
          if (n_grants < 8) n_grants++;
        end
        grant_len[n_grants - 1]++;
        low_run = 0;
      end else if (n_grants > 0) begin
        low_run++;
      end
      for (int i = 0; i < NR; i++) begin
        if (upd_req[i]) begin
          ack_cnt[i]++;
          upd_ack[i] = (ack_cnt[i] >= ack_dly[i]);
        end else begin
          ack_cnt[i] = 0;
          upd_ack[i] = 1'b0;
        end
      end
      req_or   = req_or | upd_req;
      prev_req = upd_req;
      if (!busy) begin
        busy_drop = c;
        break;
      end
    end
    err_clr = 1'b0;
    upd_ack = '0;
    VGA_VS  = 1'b1;
  endtask

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
    ack_dly[0] = d0;
    ack_dly[1] = d1;
    ack_dly[2] = d2;
    ack_dly[3] = d3;
  endtask

  initial begin
    rst         = 1'b1;
    VGA_VS      = 1'b1;
    VGA_BLANK_N = 1'b1;
    err_clr     = 1'b0;
    enable_mask = '0;
    upd_ack     = '0;
    dl_at       = -1;
    clr_at      = -1;
    retrig_at   = -1;
    mask2       = '0;
    set_dly(3, 3, 3, 3);
    step();
    step();
    step();
    rst = 1'b0;
    step();

    chk("rst_upd_req", {28'd0, upd_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_timeout_err", {28'd0, timeout_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);

    // 1: all four requesters, ack after 3 cycles of req.
    run_frame(4'b1111, 60);
    chk("t1_order", order, 32'h1234);
    chk("t1_first_req", first_req, 32'd2);
    chk("t1_len0", grant_len[0], 32'd3);
    chk("t1_len3", grant_len[3], 32'd3);
    chk("t1_gap_min", gap_min, 32'd2);
    chk("t1_gap_max", gap_max, 32'd2);
    chk("t1_busy_drop", busy_drop, 32'd22);
    chk("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("t1_timeout_err", {28'd0, timeout_err}, 32'd0);
    chk("t1_overrun", {31'd0, overrun}, 32'd0);

    // 2: sparse mask.
    run_frame(4'b0101, 60);
    chk("t2_order", order, 32'h13);
    chk("t2_req_or", {28'd0, req_or}, 32'h5);
    chk("t2_busy_drop", busy_drop, 32'd12);
    chk("t2_frame_cnt", {16'd0, frame_cnt}, 32'd2);

    // 3: requester 1 never acks.
    set_dly(3, NEVER, 3, 3);
    run_frame(4'b1111, 60);
    chk("t3_order", order, 32'h1234);
    chk("t3_len1", grant_len[1], 32'd16);
    chk("t3_gap_max", gap_max, 32'd2);
    chk("t3_timeout_err", {28'd0, timeout_err}, 32'h2);
    chk("t3_overrun", {31'd0, overrun}, 32'd0);
    chk("t3_busy_drop", busy_drop, 32'd35);
    chk("t3_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t3_clr_timeout_err", {28'd0, timeout_err}, 32'd0);

    // 4: acks withheld until active video starts.
    set_dly(NEVER, NEVER, NEVER, NEVER);
    dl_at = 10;
    run_frame(4'b1111, 60);
    chk("t4_order", order, 32'h1);
    chk("t4_len0", grant_len[0], 32'd8);
    chk("t4_req_or", {28'd0, req_or}, 32'h1);
    chk("t4_busy_drop", busy_drop, 32'd10);
    chk("t4_req_after", {28'd0, upd_req}, 32'd0);
    chk("t4_overrun", {31'd0, overrun}, 32'd1);
    chk("t4_timeout_err", {28'd0, timeout_err}, 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_clr_overrun", {31'd0, overrun}, 32'd0);

    // 5a: last ack lands on the deadline edge.
    set_dly(3, 3, 3, 3);
    dl_at = 5;
    run_frame(4'b0001, 60);
    chk("t5a_order", order, 32'h1);
    chk("t5a_len0", grant_len[0], 32'd3);
    chk("t5a_busy_drop", busy_drop, 32'd5);
    chk("t5a_overrun", {31'd0, overrun}, 32'd0);

    // 5b: same, one requester still pending, err_clr on the same edge.
    clr_at = 5;
    run_frame(4'b0011, 60);
    chk("t5b_order", order, 32'h1);
    chk("t5b_busy_drop", busy_drop, 32'd5);
    chk("t5b_overrun", {31'd0, overrun}, 32'd1);
    dl_at  = -1;
    clr_at = -1;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t5b_clr_overrun", {31'd0, overrun}, 32'd0);

    // 6: new frame trigger while requester 0 is still granted.
    set_dly(NEVER, NEVER, 3, NEVER);
    retrig_at = 6;
    mask2     = 4'b0100;
    run_frame(4'b1111, 60);
    chk("t6_order", order, 32'h13);
    chk("t6_len0", grant_len[0], 32'd4);
    chk("t6_len1", grant_len[1], 32'd3);
    chk("t6_gap", gap_min, 32'd2);
    chk("t6_busy_drop", busy_drop, 32'd13);
    chk("t6_overrun", {31'd0, overrun}, 32'd1);
    chk("t6_frame_cnt", {16'd0, frame_cnt}, 32'd8);
    retrig_at = -1;

    // 7: empty mask.
    set_dly(3, 3, 3, 3);
    run_frame(4'b0000, 20);
    chk("t7_busy_drop", busy_drop, 32'd2);
    chk("t7_req_or", {28'd0, req_or}, 32'd0);
    chk("t7_frame_cnt", {16'd0, frame_cnt}, 32'd9);

    // 8: reset while requester 0 waits for its ack.
    set_dly(NEVER, NEVER, NEVER, NEVER);
    run_frame(4'b1111, 4);
    chk("t8_pre_rst_req", {28'd0, upd_req}, 32'h1);
    rst = 1'b1;
    step();
    chk("t8_rst_upd_req", {28'd0, upd_req}, 32'd0);
    chk("t8_rst_busy", {31'd0, busy}, 32'd0);
    chk("t8_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("t8_rst_overrun", {31'd0, overrun}, 32'd0);
    chk("t8_rst_timeout_err", {28'd0, timeout_err}, 32'd0);
    rst = 1'b0;
    step();
    set_dly(3, 3, 3, 3);
    run_frame(4'b1111, 60);
    chk("t8_order", order, 32'h1234);
    chk("t8_first_req", first_req, 32'd2);
    chk("t8_busy_drop", busy_drop, 32'd22);
    chk("t8_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
